spike_encoder: RTL and testbench

SPIKE_ENCODER -- requirements
Module: spike_encoder

---
 rtl/snn_pkg.sv | 14 +
 rtl/phase_acc.sv | 43 ++++
 rtl/spike_encoder.sv | 109 ++++++++++
 tb/tb_spike_encoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the spike encoder.
package snn_pkg;

  localparam int NUM_CH = 8;   // input channels / neuron inputs
  localparam int INT_W  = 8;   // intensity and accumulator width
  localparam int CH_W   = 3;   // channel index width
  localparam int CNT_W  = 8;   // step counter width (WINDOW up to 255)

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/phase_acc.sv
// One channel of the rate encoder: intensity register, phase accumulator,
// and the carry-out that becomes this channel's spike for the current step.
module phase_acc
  import snn_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [INT_W-1:0] wr_data,
  input  logic             clear,
  input  logic             step,
  output logic             carry
);

  logic [INT_W-1:0] i_reg;
  logic [INT_W-1:0] a_reg;
  logic [INT_W-1:0] i_eff;
  logic [INT_W-1:0] a_base;
  logic [INT_W:0]   sum;

  // A write landing on the start edge must already feed step 1, so bypass it;
  // the start step also begins from a zeroed accumulator.
  always_comb begin
    i_eff  = wr_en ? wr_data : i_reg;
    a_base = clear ? '0 : a_reg;
    sum    = {1'b0, a_base} + {1'b0, i_eff};
  end

  assign carry = sum[INT_W];

  // Intensity register: only written by accepted load requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      i_reg <= '0;
    else if (wr_en) i_reg <= wr_data;
  end

  // Phase accumulator: wraps by dropping the carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              a_reg <= '0;
    else if (clear || step) a_reg <= sum[INT_W-1:0];
  end

endmodule

// File: rtl/spike_encoder.sv
// Rate-coded spike encoder: eight intensity channels presented for WINDOW
// timesteps, each channel spiking on accumulator carry-out.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [2:0] load_chan,
  input  logic [7:0] load_data,
  input  logic       start,
  input  logic       stop,
  input  logic       learn_en,
  output logic [0:7] spikes,
  output logic       learn,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               go_start, go_step;
  logic [0:NUM_CH-1]  carry;
  logic [0:NUM_CH-1]  spikes_nx;
  logic               learn_nx, done_nx;

  assign load_ready = (state == S_IDLE);
  assign busy       = (state == S_RUN);

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      phase_acc u_acc (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (load_valid && load_ready && (load_chan == CH_W'(c))),
        .wr_data (load_data),
        .clear   (go_start),
        .step    (go_step),
        .carry   (carry[c])
      );
    end
  endgenerate

  // Next-state and next-output decode; cnt holds the number of steps issued.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    go_start  = 1'b0;
    go_step   = 1'b0;
    spikes_nx = '0;
    learn_nx  = 1'b0;
    done_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx  = S_RUN;
          cnt_nx    = CNT_W'(1);
          go_start  = 1'b1;
          learn_nx  = learn_en;
          spikes_nx = carry;
        end
      end
      S_RUN: begin
        // Abort wins over completion in the same cycle.
        if (stop) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == WIN) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx    = cnt + CNT_W'(1);
          go_step   = 1'b1;
          learn_nx  = learn;
          spikes_nx = carry;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      spikes <= '0;
      learn  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      spikes <= spikes_nx;
      learn  <= learn_nx;
      done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: expected step vectors are queued at
// start and popped as each step appears on the outputs.
module tb_spike_encoder;

  localparam int W = 16;

  logic       clk, reset, load_valid, load_ready, start, stop, learn_en;
  logic       learn, busy, done;
  logic [2:0] load_chan;
  logic [7:0] load_data;
  logic [0:7] spikes;

  spike_encoder #(.WINDOW(W)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_chan(load_chan), .load_data(load_data), .start(start), .stop(stop),
    .learn_en(learn_en), .spikes(spikes), .learn(learn), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [0:7] spk;
    logic       lrn;
  } exp_t;

  exp_t       sb[$];
  int         model_i[8];
  logic [0:7] step_spk[1:W];
  logic [0:7] saved_spk[1:W];
  int         cnt[8];
  int         lrn_cnt;
  int         checks, passes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int ch, input int data);
    load_valid = 1'b1;
    load_chan  = 3'(ch);
    load_data  = 8'(data);
    tick;
    load_valid = 1'b0;
    model_i[ch] = data;
  endtask

  // Expected vectors for a whole window from the current intensity model.
  task automatic push_window(input logic lrn);
    int   acc[8];
    int   s;
    exp_t e;
    for (int c = 0; c < 8; c++) acc[c] = 0;
    for (int k = 1; k <= W; k++) begin
      e.lrn = lrn;
      for (int c = 0; c < 8; c++) begin
        s = acc[c] + model_i[c];
        e.spk[c] = (s >= 256);
        acc[c] = s % 256;
      end
      sb.push_back(e);
    end
  endtask

  // One presentation; optional write with start, write during RUN, stop at a step.
  task automatic run_window(input logic lrn, input int stop_step, input bit wr_start,
                            input int wr_ch, input int wr_data, input int run_wr_step);
    exp_t e;
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    lrn_cnt = 0;
    if (wr_start) begin
      load_valid = 1'b1;
      load_chan  = 3'(wr_ch);
      load_data  = 8'(wr_data);
      model_i[wr_ch] = wr_data;
    end
    start = 1'b1;
    learn_en = lrn;
    push_window(lrn);
    tick;
    start = 1'b0;
    learn_en = 1'b0;
    load_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      e = sb.pop_front();
      checks++;
      if (spikes !== e.spk) $display("FAIL step%0d_spikes: got %b required %b", k, spikes, e.spk);
      else passes++;
      checks++;
      if (learn !== e.lrn) $display("FAIL step%0d_learn: got %b required %b", k, learn, e.lrn);
      else passes++;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || load_ready !== 1'b0)
        $display("FAIL step%0d_status: got busy=%b done=%b ready=%b required 1/0/0", k, busy, done, load_ready);
      else passes++;
      step_spk[k] = spikes;
      for (int c = 0; c < 8; c++) if (spikes[c] === 1'b1) cnt[c]++;
      if (learn === 1'b1) lrn_cnt++;
      if (run_wr_step == k) begin
        load_valid = 1'b1;
        load_chan  = 3'd2;
        load_data  = 8'd200;
      end
      if (stop_step == k) begin
        stop = 1'b1;
        tick;
        stop = 1'b0;
        load_valid = 1'b0;
        sb.delete();
        checks++;
        if (spikes !== 8'b0 || learn !== 1'b0 || done !== 1'b0)
          $display("FAIL stop_outputs: got spikes=%b learn=%b done=%b required 0/0/0", spikes, learn, done);
        else passes++;
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b1)
          $display("FAIL stop_state: got busy=%b ready=%b required 0/1", busy, load_ready);
        else passes++;
        tick;
        checks++;
        if (done !== 1'b0) $display("FAIL stop_no_done: got %b required 0", done);
        else passes++;
        return;
      end
      tick;
      load_valid = 1'b0;
    end
    checks++;
    if (done !== 1'b1) $display("FAIL done_pulse: got %b required 1", done);
    else passes++;
    checks++;
    if (spikes !== 8'b0 || learn !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1)
      $display("FAIL end_state: got spikes=%b learn=%b busy=%b ready=%b required 0/0/0/1",
               spikes, learn, busy, load_ready);
    else passes++;
    tick;
    checks++;
    if (done !== 1'b0) $display("FAIL done_one_cycle: got %b required 0", done);
    else passes++;
  endtask

  task automatic test_reset;
    reset = 1'b1; load_valid = 1'b0; load_chan = '0; load_data = '0;
    start = 1'b0; stop = 1'b0; learn_en = 1'b0;
    for (int c = 0; c < 8; c++) model_i[c] = 0;
    tick; tick;
    reset = 1'b0;
    tick;
    checks++;
    if (spikes !== 8'b0 || learn !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_outputs: got spikes=%b learn=%b done=%b required 0/0/0", spikes, learn, done);
    else passes++;
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1)
      $display("FAIL reset_state: got busy=%b ready=%b required 0/1", busy, load_ready);
    else passes++;
    // stop in IDLE is ignored
    stop = 1'b1; tick; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_stop: got busy=%b done=%b required 0/0", busy, done);
    else passes++;
  endtask

  task automatic test_half_rate;
    do_load(0, 128);
    run_window(1'b0, 0, 1'b0, 0, 0, 0);
    checks++;
    if (cnt[0] !== 8) $display("FAIL half_count: got %0d required 8", cnt[0]);
    else passes++;
    for (int k = 1; k <= W; k++) begin
      checks++;
      if (step_spk[k][0] !== ((k % 2) == 0)) $display("FAIL half_step%0d: got %b required %b", k, step_spk[k][0], (k % 2) == 0);
      else passes++;
    end
  endtask

  task automatic test_multi_rate;
    do_load(1, 255); do_load(2, 1); do_load(3, 16); do_load(4, 0);
    run_window(1'b0, 0, 1'b0, 0, 0, 0);
    checks++;
    if (cnt[1] !== 15 || cnt[2] !== 0 || cnt[3] !== 1 || cnt[4] !== 0)
      $display("FAIL multi_counts: got %0d/%0d/%0d/%0d required 15/0/1/0", cnt[1], cnt[2], cnt[3], cnt[4]);
    else passes++;
    checks++;
    if (step_spk[16][3] !== 1'b1) $display("FAIL ch3_step16: got %b required 1", step_spk[16][3]);
    else passes++;
    checks++;
    if (step_spk[1][1] !== 1'b0) $display("FAIL ch1_step1: got %b required 0", step_spk[1][1]);
    else passes++;
    checks++;
    if (cnt[0] !== 8) $display("FAIL ch0_kept: got %0d required 8", cnt[0]);
    else passes++;
  endtask

  task automatic test_learn;
    checks++;
    if (learn !== 1'b0) $display("FAIL learn_before: got %b required 0", learn);
    else passes++;
    run_window(1'b1, 0, 1'b0, 0, 0, 0);
    checks++;
    if (lrn_cnt !== 16) $display("FAIL learn_cycles: got %0d required 16", lrn_cnt);
    else passes++;
  endtask

  task automatic test_stop_restart;
    run_window(1'b0, 5, 1'b0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) saved_spk[k] = step_spk[k];
    run_window(1'b0, 0, 1'b0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (step_spk[k] !== saved_spk[k]) $display("FAIL restart_step%0d: got %b required %b", k, step_spk[k], saved_spk[k]);
      else passes++;
    end
  endtask

  task automatic test_load_with_start;
    run_window(1'b0, 0, 1'b1, 2, 64, 3);
    for (int k = 1; k <= W; k++) begin
      checks++;
      if (step_spk[k][2] !== ((k % 4) == 0)) $display("FAIL ch2_step%0d: got %b required %b", k, step_spk[k][2], (k % 4) == 0);
      else passes++;
    end
    run_window(1'b0, 0, 1'b0, 0, 0, 0);
    checks++;
    if (cnt[2] !== 4) $display("FAIL run_write_ignored: got %0d required 4", cnt[2]);
    else passes++;
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1; learn_en = 1'b1;
    tick;
    start = 1'b0; learn_en = 1'b0;
    // start while running is ignored
    start = 1'b1; tick; start = 1'b0;
    repeat (5) tick;
    checks++;
    if (busy !== 1'b1 || spikes[1] !== 1'b1 || learn !== 1'b1)
      $display("FAIL pre_reset_step7: got busy=%b spk1=%b learn=%b required 1/1/1", busy, spikes[1], learn);
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if (spikes !== 8'b0 || learn !== 1'b0 || done !== 1'b0)
      $display("FAIL async_reset_outputs: got spikes=%b learn=%b done=%b required 0/0/0", spikes, learn, done);
    else passes++;
    checks++;
    if (busy !== 1'b0 || load_ready !== 1'b1)
      $display("FAIL async_reset_state: got busy=%b ready=%b required 0/1", busy, load_ready);
    else passes++;
    for (int c = 0; c < 8; c++) model_i[c] = 0;
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (done !== 1'b0) $display("FAIL reset_no_done: got %b required 0", done);
    else passes++;
    run_window(1'b0, 0, 1'b0, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (cnt[c] !== 0) $display("FAIL cleared_ch%0d: got %0d required 0", c, cnt[c]);
      else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset;
    test_half_rate;
    test_multi_rate;
    test_learn;
    test_stop_restart;
    test_load_with_start;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
